uart_tx_framer: RTL and testbench

//  Parametrised UART transmit framer: buffers parallel words in a FIFO and builds complete frames
//  (start, 5..MAX_DATA_W data bits, optional parity, 1 or 2 stop bits, or break).

---
 rtl/uart_tx_framer_if.sv | 27 ++
 rtl/uart_tx_framer.sv | 105 ++++++++++
 tb/tb_uart_tx_framer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: host write side and PISO frame side of the UART TX framer
interface uart_tx_framer_if #(
    parameter int MAX_DATA_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_W    = MAX_DATA_W + 4
);
    logic [5:0]                         line_control_reg;
    logic [MAX_DATA_W-1:0]              data_in;
    logic                               data_valid;
    logic                               data_ready;
    logic [FRAME_W-1:0]                 frame_out;
    logic [$clog2(FRAME_W+1)-1:0]       frame_len;
    logic                               frame_valid;
    logic                               frame_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;
    logic                               overrun;

    modport master (
        output line_control_reg, data_in, data_valid, frame_ready,
        input  data_ready, frame_out, frame_len, frame_valid, fifo_count, overrun
    );

    modport slave (
        input  line_control_reg, data_in, data_valid, frame_ready,
        output data_ready, frame_out, frame_len, frame_valid, fifo_count, overrun
    );
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: word FIFO feeding a registered UART frame builder (start/data/parity/stop or break)
module uart_tx_framer #(
    parameter int MAX_DATA_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_W    = MAX_DATA_W + 4
) (
    input logic             baud_clk,
    input logic             rst,
    uart_tx_framer_if.slave bus
);
    localparam int LW = $clog2(FRAME_W + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, LOADED} state_t;

    state_t                 r_state;
    logic [MAX_DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr;
    logic [AW-1:0]          r_rd;
    logic [CW-1:0]          r_count;
    logic [FRAME_W-1:0]     r_frame;
    logic [LW-1:0]          r_len;
    logic                   r_overrun;

    logic                   w_brk, w_stop2, w_p, w_pe;
    logic [1:0]             w_dw;
    logic                   w_full, w_empty, w_push, w_take, w_pop, w_build;
    logic [MAX_DATA_W-1:0]  w_head;
    int                     w_n;
    logic [LW-1:0]          w_len;
    logic [FRAME_W-1:0]     w_frame;
    logic                   w_par;

    assign {w_brk, w_stop2, w_p, w_pe, w_dw} = bus.line_control_reg;
    assign w_full  = r_count == CW'(FIFO_DEPTH);
    assign w_empty = r_count == '0;
    assign w_push  = bus.data_valid && !w_full;
    // The output register can take a new frame when empty or handing its frame over this edge
    assign w_take  = (r_state == IDLE) || bus.frame_ready;
    // Break frames are generated without consuming buffered words
    assign w_pop   = w_take && !w_brk && !w_empty;
    assign w_build = w_take && (w_brk || !w_empty);
    assign w_head  = r_mem[r_rd];
    assign w_n     = MAX_DATA_W - 3 + int'(w_dw);
    assign w_len   = LW'(w_n + 2 + int'(w_pe) + int'(w_stop2));

    // Assemble the frame for the oldest word: idle-high background, start, data LSB first, parity
    always_comb begin
        w_frame = '1;
        w_par   = 1'b0;
        w_frame[0] = 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < w_n) begin
                w_frame[i+1] = w_head[i];
                w_par        = w_par ^ w_head[i];
            end
        end
        for (int i = 1; i < FRAME_W; i++) begin
            if (w_pe && i == w_n + 1) w_frame[i] = w_p ? w_par : ~w_par;
        end
    end

    // Word storage; contents need no reset since the count gates every read
    always_ff @(posedge baud_clk) begin
        if (w_push) r_mem[r_wr] <= bus.data_in;
    end

    // FIFO pointers, occupancy and the overrun pulse for writes refused while full
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_overrun <= bus.data_valid && w_full;
        end
    end

    // Output register FSM: hold a loaded frame until accepted, rebuilding on the same edge when possible
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_frame <= '1;
            r_len   <= '0;
        end else if (w_build) begin
            r_state <= LOADED;
            r_frame <= w_brk ? '0 : w_frame;
            r_len   <= w_brk ? LW'(FRAME_W) : w_len;
        end else if (r_state == LOADED && bus.frame_ready) begin
            r_state <= IDLE;
        end
    end

    assign bus.data_ready  = !w_full;
    assign bus.fifo_count  = r_count;
    assign bus.frame_out   = r_frame;
    assign bus.frame_len   = r_len;
    assign bus.frame_valid = r_state == LOADED;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed checks of framing, FIFO flow control, break and async reset
module tb_uart_tx_framer;
    logic baud_clk;
    logic rst;
    int   checks;
    int   passed;

    uart_tx_framer_if #(.MAX_DATA_W(8), .FIFO_DEPTH(4)) bus ();

    uart_tx_framer #(.MAX_DATA_W(8), .FIFO_DEPTH(4)) dut (
        .baud_clk (baud_clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] out, input logic [31:0] len);
        chk({tag, "_valid"}, 32'(bus.frame_valid), 32'd1);
        chk({tag, "_out"},   32'(bus.frame_out),   out);
        chk({tag, "_len"},   32'(bus.frame_len),   len);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, "_out"},   32'(bus.frame_out),   32'hFFF);
        chk({tag, "_len"},   32'(bus.frame_len),   32'd0);
        chk({tag, "_count"}, 32'(bus.fifo_count),  32'd0);
        chk({tag, "_ready"}, 32'(bus.data_ready),  32'd1);
        chk({tag, "_ovr"},   32'(bus.overrun),     32'd0);
    endtask

    task automatic push(input logic [7:0] w);
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        bus.line_control_reg = 6'b000000;
        bus.data_in          = 8'h00;
        bus.data_valid       = 1'b0;
        bus.frame_ready      = 1'b0;
        #2;
        chk_reset("rst0");
        #10;
        rst = 1'b0;

        // 8N1, 0xA5; push is not bypassed, frame appears one edge later
        bus.line_control_reg = 6'b000011;
        push(8'hA5);
        chk("t1_nobypass", 32'(bus.frame_valid), 32'd0);
        chk("t1_cnt1",     32'(bus.fifo_count),  32'd1);
        tick();
        chk_frame("t1", 32'hF4A, 32'd10);
        chk("t1_cnt0", 32'(bus.fifo_count), 32'd0);
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        chk("t1_idle", 32'(bus.frame_valid), 32'd0);

        // 5 data bits, even parity
        bus.line_control_reg = 6'b001100;
        push(8'h07);
        tick();
        chk_frame("t2", 32'hFCE, 32'd8);
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;

        // 8 data bits, odd parity, 2 stop bits
        bus.line_control_reg = 6'b010111;
        push(8'h00);
        tick();
        chk_frame("t3", 32'hE00, 32'd12);
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;

        // Fill FIFO behind a held frame, overflow once, then drain back-to-back
        bus.line_control_reg = 6'b000011;
        push(8'h11);
        tick();
        chk_frame("t4_held", 32'hE22, 32'd10);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        chk("t4_full_cnt",   32'(bus.fifo_count), 32'd4);
        chk("t4_full_ready", 32'(bus.data_ready), 32'd0);
        chk("t4_no_ovr",     32'(bus.overrun),    32'd0);
        bus.line_control_reg = 6'b001100;
        push(8'h66);
        chk("t4_ovr",      32'(bus.overrun),    32'd1);
        chk("t4_ovr_cnt",  32'(bus.fifo_count), 32'd4);
        chk_frame("t4_lcr_hold", 32'hE22, 32'd10);
        bus.line_control_reg = 6'b000011;
        tick();
        chk("t4_ovr_end", 32'(bus.overrun), 32'd0);
        bus.frame_ready = 1'b1;
        tick();
        chk_frame("t4_f2", 32'hE44, 32'd10);
        tick();
        chk_frame("t4_f3", 32'hE66, 32'd10);
        tick();
        chk_frame("t4_f4", 32'hE88, 32'd10);
        tick();
        chk_frame("t4_f5", 32'hEAA, 32'd10);
        chk("t4_empty", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("t4_idle", 32'(bus.frame_valid), 32'd0);
        bus.frame_ready = 1'b0;

        // Break holds queued words while emitting all-zero frames
        bus.line_control_reg = 6'b100011;
        push(8'h01);
        push(8'h02);
        chk_frame("t5_brk0", 32'h000, 32'd12);
        chk("t5_cnt2", 32'(bus.fifo_count), 32'd2);
        bus.frame_ready = 1'b1;
        tick();
        chk_frame("t5_brk1", 32'h000, 32'd12);
        chk("t5_cnt2b", 32'(bus.fifo_count), 32'd2);
        tick();
        chk_frame("t5_brk2", 32'h000, 32'd12);
        bus.line_control_reg = 6'b000011;
        tick();
        chk_frame("t5_w1", 32'hE02, 32'd10);
        chk("t5_cnt1", 32'(bus.fifo_count), 32'd1);
        tick();
        chk_frame("t5_w2", 32'hE04, 32'd10);
        chk("t5_cnt0", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("t5_idle", 32'(bus.frame_valid), 32'd0);
        bus.frame_ready = 1'b0;

        // Asynchronous reset with a loaded frame and three queued words
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        chk_frame("t6_pre", 32'hE20, 32'd10);
        chk("t6_cnt3", 32'(bus.fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("t6_async");
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_reset("t6_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
